// File: rtl/lsu_split_if.sv
// rtl/lsu_split_if.sv - Data-side bus beat interface between lsu_split and the bus master.
interface lsu_split_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              io_reqValid;
  logic              io_respValid;
  logic              io_respErr;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;
  logic [1:0]        io_size;
  logic              io_wen;
  logic [BYTES-1:0]  io_wmask;

  modport master (
    output io_reqValid, io_addr, io_wdata, io_size, io_wen, io_wmask,
    input  io_respValid, io_respErr, io_rdata
  );

  modport slave (
    input  io_reqValid, io_addr, io_wdata, io_size, io_wen, io_wmask,
    output io_respValid, io_respErr, io_rdata
  );
endinterface

// File: rtl/lsu_split.sv
// rtl/lsu_split.sv - Load/store unit that latches requests and splits bus-word-crossing accesses into two beats.
// Optional LSU_MISALIGN_TRAP_EN: crossing accesses are rejected with an error instead of being split.
module lsu_split #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        data_size,
  input  logic              is_mem_sign,
  output logic              respValid,
  output logic              respErr,
  output logic [DATA_W-1:0] rdata,
  lsu_split_if.master       bus
);
  localparam int BYTES  = DATA_W / 8;
  localparam int OFF    = $clog2(BYTES);
  localparam bit NARROW = (DATA_W == 32);

  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_e;

  state_e              state_q, state_d;
  logic                wr_q, sign_q, cross_q;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   beat_q, beat_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                accept;
  logic [OFF-1:0]      in_off;
  logic [3:0]          in_n;
  logic                in_cross, in_illegal;

  logic [OFF-1:0]      off_q;
  logic [ADDR_W-1:0]   addr_al;
  logic [15:0]         base16;
  logic [2*BYTES-1:0]  mask_full;
  logic [2*DATA_W-1:0] wdbl;
  logic [DATA_W-1:0]   wrot;
  logic [DATA_W-1:0]   asm_hi, asm_lo;
  logic [2*DATA_W-1:0] asm_sh;
  logic [DATA_W-1:0]   aligned, load_ext;
  logic                ext_msb;
  int                  nbits;

  assign accept     = (state_q == IDLE) && reqValid;
  assign in_off     = addr[OFF-1:0];
  assign in_n       = 4'd1 << data_size;
  assign in_cross   = (int'(in_off) + int'(in_n)) > BYTES;
  assign in_illegal = NARROW && (data_size == 2'd3);

  assign off_q   = addr_q[OFF-1:0];
  assign addr_al = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};

  // Byte-lane mask and rotated store data span two bus words; each beat takes its half.
  always_comb begin
    base16 = 16'h0000;
    case (size_q)
      2'd0:    base16 = 16'h0001;
      2'd1:    base16 = 16'h0003;
      2'd2:    base16 = 16'h000F;
      default: base16 = 16'h00FF;
    endcase
  end

  assign mask_full = base16[2*BYTES-1:0] << off_q;
  assign wdbl      = {wdata_q, wdata_q} << {off_q, 3'b000};
  assign wrot      = wdbl[2*DATA_W-1:DATA_W];

  // Beat 1 data sits in beat_q while beat 2 is on io_rdata; single beats use io_rdata alone.
  assign asm_hi  = (state_q == BEAT2) ? bus.io_rdata : '0;
  assign asm_lo  = (state_q == BEAT2) ? beat_q : bus.io_rdata;
  assign asm_sh  = {asm_hi, asm_lo} >> {off_q, 3'b000};
  assign aligned = asm_sh[DATA_W-1:0];

  always_comb begin
    nbits   = 8 << size_q;
    ext_msb = 1'b0;
    case (size_q)
      2'd0:    ext_msb = aligned[7];
      2'd1:    ext_msb = aligned[15];
      2'd2:    ext_msb = aligned[31];
      default: ext_msb = aligned[DATA_W-1];
    endcase
    load_ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i < nbits) ? aligned[i] : (sign_q & ext_msb);
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (reqValid) begin
          err_d   = 1'b0;
          state_d = BEAT1;
          if (in_illegal) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (in_cross) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
`endif
        end
      end
      BEAT1: begin
        if (bus.io_respValid) begin
          if (bus.io_respErr) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (cross_q) begin
            beat_d  = bus.io_rdata;
            state_d = BEAT2;
          end else begin
            err_d   = 1'b0;
            rdata_d = wr_q ? '0 : load_ext;
            state_d = RESP;
          end
        end
      end
      BEAT2: begin
        if (bus.io_respValid) begin
          err_d   = bus.io_respErr;
          rdata_d = (wr_q || bus.io_respErr) ? '0 : load_ext;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      sign_q  <= 1'b0;
      cross_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'd0;
      beat_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
      if (accept) begin
        wr_q    <= is_write;
        sign_q  <= is_mem_sign;
        cross_q <= in_cross;
        addr_q  <= addr;
        wdata_q <= wdata;
        size_q  <= data_size;
      end
    end
  end

  assign reqReady  = (state_q == IDLE);
  assign respValid = (state_q == RESP);
  assign respErr   = (state_q == RESP) && err_q;
  assign rdata     = rdata_q;

  always_comb begin
    bus.io_reqValid = (state_q == BEAT1) || (state_q == BEAT2);
    bus.io_wen      = wr_q && bus.io_reqValid;
    bus.io_wdata    = wrot;
    bus.io_wmask    = '0;
    bus.io_addr     = cross_q ? addr_al : addr_q;
    bus.io_size     = cross_q ? 2'(OFF) : size_q;
    if (state_q == BEAT1) begin
      bus.io_wmask = mask_full[BYTES-1:0];
    end else if (state_q == BEAT2) begin
      bus.io_wmask = mask_full[2*BYTES-1:BYTES];
      bus.io_addr  = addr_al + ADDR_W'(BYTES);
      bus.io_size  = 2'(OFF);
    end
  end
endmodule
